trivia_sc_sequencer: RTL and testbench
======================================

Name: trivia_sc_sequencer

Overview:
- Sequencing controller for the TriviA 384-bit stream-cipher state block.
- Drives the block's 64-round update strobe (load_SC64) and tag-insert strobe (insertSC) through initialization, keystream streaming, tag insertion and finalization.
- Exposes a valid/ready keystream handshake to the encrypt/decrypt datapath. One session per reset, because the cipher state block loads key/IV only on rst.

Parameters:
INIT_BLOCKS, 18, number of 64-round updates (1152 rounds) issued during initialization; must be >= 1
FINAL_BLOCKS, 8, number of 64-round updates issued after the last keystream block; 0 allowed
CNT_W, 6, block counter width; must hold max(INIT_BLOCKS, FINAL_BLOCKS) - 1

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
start  in  1  begin session; honoured only in IDLE
ks_ready  in  1  consumer takes the current Z word
blk_last  in  1  qualifies ks_ready: accepted word is the final data block
ins_req  in  1  request one tag-insert cycle
load_SC64  out  1  64-round update strobe to the state block
insertSC  out  1  tag-XOR strobe to the state block
ks_valid  out  1  Z from the state block is valid keystream this cycle
busy  out  1  session in progress (INIT, STREAM, INSERT, FINAL)
done  out  1  finalization complete; Z holds the tag word; level until rst
err  out  1  one-cycle registered pulse: start seen outside IDLE
upd_cnt  out  32  count of load_SC64 cycles (see Optional Feature)

Behaviour:
- Reset (async) values: state IDLE, counter 0, err 0. load_SC64, insertSC, ks_valid, busy, done are decoded from state, so all read 0 immediately on rst.
- States: IDLE, INIT, STREAM, INSERT, FINAL, DONE.
- IDLE: all strobes 0. start=1 -> INIT, cnt=0.
- INIT:
  - load_SC64=1 every cycle; cnt increments.
  - On cnt==INIT_BLOCKS-1 -> STREAM and cnt clears.
  - Result: exactly INIT_BLOCKS consecutive pulses, the first in the cycle after start was sampled.
- STREAM:
  - ks_valid=1 and load_SC64 = ks_ready & ~ins_req (combinational).
  - ins_req=1 has priority: load_SC64=0 this cycle, -> INSERT, Z not consumed.
  - Else ks_ready=1: word accepted, load_SC64=1. With blk_last=1: -> FINAL if FINAL_BLOCKS>0, else -> DONE.
  - ks_ready=0: hold, ks_valid stays 1, Z unchanged.
- INSERT: insertSC=1 for exactly one cycle, ks_valid=0, load_SC64=0; -> STREAM.
- FINAL: load_SC64=1 each cycle for FINAL_BLOCKS cycles (counter as INIT); -> DONE.
- DONE: done=1; all strobes 0; sticky until rst.
- Ignored inputs:
  - ins_req, ks_ready and blk_last are ignored outside STREAM; no queuing.
  - blk_last without ks_ready is ignored.
- start outside IDLE: no state effect; err=1 on the following cycle, for one cycle. start in the same cycle as rst deassertion is sampled normally on the next edge.
- Mutual exclusion: load_SC64 and insertSC are never both 1. ks_valid and insertSC are never both 1.
- Reset mid-operation: immediate return to IDLE, counter 0, all outputs 0. A partially updated cipher state is discarded because the state block also resets.
- Latency:
  - start -> first ks_valid = INIT_BLOCKS+1 cycles.
  - last accept -> done = FINAL_BLOCKS+1 cycles.

Optional Feature:
- Macro TRIVIA_SC_UPD_CNT_EN.
- Defined:
  - upd_cnt is a 32-bit register, reset to 0, incremented on every cycle with load_SC64=1.
  - It wraps from 0xFFFFFFFF to 0, is not cleared by start, and holds in DONE.
- Undefined: upd_cnt is tied to 32'h0 and no counter logic is synthesized.

Test Plan:
- Reset, start pulse at cycle 0 -> load_SC64=1 on cycles 1..18, ks_valid=1 from cycle 19, busy=1 from cycle 1; upd_cnt=18 at cycle 19 (macro on).
- In STREAM, ks_ready=1 for 4 cycles with blk_last on the 4th -> 4 load_SC64 pulses, then FINAL with 8 further pulses, done=1 exactly 9 cycles after the last accept, busy=0.
- In STREAM, ins_req=1 together with ks_ready=1 -> load_SC64=0 and that word is not consumed; next cycle insertSC=1 and ks_valid=0; following cycle ks_valid=1 again.
- start=1 during INIT and again in DONE -> err pulses for one cycle after each; state and counter unaffected.
- rst asserted at INIT block 10 -> all outputs 0 immediately; after release and start, a fresh 18-pulse INIT; upd_cnt=0 after reset.
- FINAL_BLOCKS=0 build: accept with blk_last -> done=1 the next cycle, with no extra load_SC64 pulses.

Source files
------------

// File: rtl/trivia_sc_sequencer.sv
// Sequencing controller for the TriviA 384-bit stream-cipher state block.
// Walks one session per reset: IDLE -> INIT -> STREAM <-> INSERT -> FINAL -> DONE,
// driving the 64-round update strobe (load_SC64) and tag-insert strobe (insertSC)
// and presenting a valid/ready keystream handshake to the datapath.
// Optional feature: define TRIVIA_SC_UPD_CNT_EN to build the 32-bit update counter
// on upd_cnt; otherwise upd_cnt is tied to zero.
module trivia_sc_sequencer #(
    parameter int unsigned INIT_BLOCKS  = 18,
    parameter int unsigned FINAL_BLOCKS = 8,
    parameter int unsigned CNT_W        = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        ks_ready,
    input  logic        blk_last,
    input  logic        ins_req,
    output logic        load_SC64,
    output logic        insertSC,
    output logic        ks_valid,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] upd_cnt
);

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StInit   = 3'd1;
    localparam logic [2:0] StStream = 3'd2;
    localparam logic [2:0] StInsert = 3'd3;
    localparam logic [2:0] StFinal  = 3'd4;
    localparam logic [2:0] StDone   = 3'd5;

    localparam bit HasFinal = (FINAL_BLOCKS != 0);
    localparam logic [CNT_W-1:0] InitLast  = CNT_W'(INIT_BLOCKS - 1);
    // Guarded so a zero-length finalization does not wrap the constant.
    localparam logic [CNT_W-1:0] FinalLast = HasFinal ? CNT_W'(FINAL_BLOCKS - 1) : '0;

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    // Next-state and block-counter logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StInit;
                    cnt_d   = '0;
                end
            end
            StInit: begin
                if (cnt_q == InitLast) begin
                    state_d = StStream;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StStream: begin
                // Insert request wins over an accept; the current word stays put.
                if (ins_req) begin
                    state_d = StInsert;
                end else if (ks_ready && blk_last) begin
                    state_d = HasFinal ? StFinal : StDone;
                    cnt_d   = '0;
                end
            end
            StInsert: state_d = StStream;
            StFinal: begin
                if (cnt_q == FinalLast) begin
                    state_d = StDone;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StDone:  state_d = StDone;
            default: state_d = StIdle;
        endcase
    end

    // A start seen anywhere but IDLE is flagged one cycle later.
    always_comb begin
        err_d = start && (state_q != StIdle);
    end

    // State, counter and error registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Outputs decoded from state so they drop the moment rst asserts.
    always_comb begin
        load_SC64 = (state_q == StInit) || (state_q == StFinal) ||
                    ((state_q == StStream) && ks_ready && !ins_req);
        insertSC  = (state_q == StInsert);
        ks_valid  = (state_q == StStream);
        busy      = (state_q == StInit) || (state_q == StStream) ||
                    (state_q == StInsert) || (state_q == StFinal);
        done      = (state_q == StDone);
        err       = err_q;
    end

`ifdef TRIVIA_SC_UPD_CNT_EN
    logic [31:0] upd_q;

    // Free-running count of update strobes; survives start, wraps naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            upd_q <= '0;
        end else if (load_SC64) begin
            upd_q <= upd_q + 32'd1;
        end
    end

    assign upd_cnt = upd_q;
`else
    assign upd_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_trivia_sc_sequencer.sv
// Self-checking bench for trivia_sc_sequencer: a default instance (18/8) and a
// zero-finalization instance (2/0) share stimulus; both are compared each cycle
// against a counter-based session model, plus directed vector tables.
module tb_trivia_sc_sequencer;

`ifdef TRIVIA_SC_UPD_CNT_EN
    localparam bit UPD = 1'b1;
`else
    localparam bit UPD = 1'b0;
`endif

    logic clk, rst, start, ks_ready, blk_last, ins_req;
    logic load_a, ins_a, valid_a, busy_a, done_a, err_a;
    logic load_b, ins_b, valid_b, busy_b, done_b, err_b;
    logic [31:0] upd_a, upd_b;

    trivia_sc_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .ks_ready(ks_ready), .blk_last(blk_last),
        .ins_req(ins_req), .load_SC64(load_a), .insertSC(ins_a), .ks_valid(valid_a),
        .busy(busy_a), .done(done_a), .err(err_a), .upd_cnt(upd_a)
    );

    trivia_sc_sequencer #(.INIT_BLOCKS(2), .FINAL_BLOCKS(0), .CNT_W(2)) dut0 (
        .clk(clk), .rst(rst), .start(start), .ks_ready(ks_ready), .blk_last(blk_last),
        .ins_req(ins_req), .load_SC64(load_b), .insertSC(ins_b), .ks_valid(valid_b),
        .busy(busy_b), .done(done_b), .err(err_b), .upd_cnt(upd_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Session model: remaining-block counts instead of an explicit state.
    typedef struct packed {
        int          init_left;
        int          final_left;
        bit          stream;
        bit          ins;
        bit          done;
        bit          err;
        int unsigned upd;
    } mdl_t;

    typedef struct packed {
        bit         s, r, l, i;
        logic [5:0] exp;
    } vec_t;

    mdl_t m, m0;
    int   total, bad;

    function automatic bit m_busy(mdl_t x);
        return (x.init_left > 0) || (x.final_left > 0) || x.stream || x.ins;
    endfunction

    // Expected {load, insert, valid, busy, done, err}.
    function automatic logic [5:0] mout(mdl_t x, bit r, bit i);
        bit ld;
        ld = (x.init_left > 0) || (x.final_left > 0) || (x.stream && r && !i);
        return {ld, x.ins, x.stream, m_busy(x), x.done, x.err};
    endfunction

    function automatic mdl_t mnext(mdl_t x, bit s, bit r, bit l, bit i, int ini, int fin);
        mdl_t       n;
        logic [5:0] o;
        n = x;
        o = mout(x, r, i);
        n.err = s && (m_busy(x) || x.done);
        n.upd = x.upd + (o[5] ? 32'd1 : 32'd0);
        if (!m_busy(x) && !x.done) begin
            if (s) n.init_left = ini;
        end else if (x.init_left > 0) begin
            n.init_left = x.init_left - 1;
            if (n.init_left == 0) n.stream = 1'b1;
        end else if (x.final_left > 0) begin
            n.final_left = x.final_left - 1;
            if (n.final_left == 0) n.done = 1'b1;
        end else if (x.ins) begin
            n.ins    = 1'b0;
            n.stream = 1'b1;
        end else if (x.stream) begin
            if (i) begin
                n.stream = 1'b0;
                n.ins    = 1'b1;
            end else if (r && l) begin
                n.stream = 1'b0;
                if (fin > 0) n.final_left = fin;
                else n.done = 1'b1;
            end
        end
        return n;
    endfunction

    function automatic vec_t mk(bit s, bit r, bit l, bit i, logic [5:0] e);
        vec_t v;
        v.s = s; v.r = r; v.l = l; v.i = i; v.exp = e;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input bit s, input bit r, input bit l, input bit i,
                        output logic [5:0] o, output logic [5:0] o0, output logic [31:0] u);
        start = s; ks_ready = r; blk_last = l; ins_req = i;
        @(negedge clk);
        o  = {load_a, ins_a, valid_a, busy_a, done_a, err_a};
        o0 = {load_b, ins_b, valid_b, busy_b, done_b, err_b};
        u  = upd_a;
        chk("model outs", 32'(o), 32'(mout(m, r, i)));
        chk("model upd", upd_a, UPD ? m.upd : 32'd0);
        chk("model0 outs", 32'(o0), 32'(mout(m0, r, i)));
        chk("model0 upd", upd_b, UPD ? m0.upd : 32'd0);
        @(posedge clk);
        m  = mnext(m, s, r, l, i, 18, 8);
        m0 = mnext(m0, s, r, l, i, 2, 0);
        #1;
    endtask

    // Entered just after a rising edge; checks outputs drop asynchronously.
    task automatic do_reset();
        start = 0; ks_ready = 0; blk_last = 0; ins_req = 0;
        rst = 1'b1;
        #1;
        chk("rst outs", 32'({load_a, ins_a, valid_a, busy_a, done_a, err_a}), 32'd0);
        chk("rst outs0", 32'({load_b, ins_b, valid_b, busy_b, done_b, err_b}), 32'd0);
        chk("rst upd", upd_a, 32'd0);
        m  = '0;
        m0 = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    vec_t       tbl [20];
    logic [5:0] o, o0;
    logic [31:0] u;

    initial begin
        total = 0; bad = 0;
        rst = 1'b1; start = 0; ks_ready = 0; blk_last = 0; ins_req = 0;
        m = '0; m0 = '0;

        // Stream-phase vectors following a full INIT.
        tbl[0]  = mk(0, 0, 0, 0, 6'b001100);
        tbl[1]  = mk(0, 1, 0, 1, 6'b001100);
        tbl[2]  = mk(0, 1, 0, 0, 6'b010100);
        tbl[3]  = mk(0, 1, 0, 0, 6'b101100);
        tbl[4]  = mk(1, 0, 0, 0, 6'b001100);
        tbl[5]  = mk(0, 1, 0, 0, 6'b101101);
        tbl[6]  = mk(0, 1, 0, 0, 6'b101100);
        tbl[7]  = mk(0, 1, 1, 0, 6'b101100);
        for (int k = 8; k < 16; k++) tbl[k] = mk(0, 0, 0, 0, 6'b100100);
        tbl[9]  = mk(0, 1, 1, 1, 6'b100100);
        tbl[16] = mk(0, 0, 0, 0, 6'b000010);
        tbl[17] = mk(1, 0, 0, 0, 6'b000010);
        tbl[18] = mk(0, 0, 0, 0, 6'b000011);
        tbl[19] = mk(0, 0, 0, 0, 6'b000010);

        @(posedge clk);
        #1;
        do_reset();

        // Reset in the middle of INIT (block 10).
        step(1, 0, 0, 0, o, o0, u);
        for (int i = 1; i <= 10; i++) step(0, 0, 0, 0, o, o0, u);
        do_reset();

        // Fresh session; start in the cycle right after rst release.
        step(1, 0, 0, 0, o, o0, u);
        chk("idle outs", 32'(o), 32'd0);
        chk("upd after reset", u, 32'd0);
        for (int i = 1; i <= 18; i++) begin
            step((i == 5), 0, 0, 0, o, o0, u);
            chk($sformatf("init cyc%0d", i), 32'(o), 32'({5'b10010, (i == 6)}));
        end

        for (int k = 0; k < 20; k++) begin
            step(tbl[k].s, tbl[k].r, tbl[k].l, tbl[k].i, o, o0, u);
            chk($sformatf("vec%0d", k), 32'(o), 32'(tbl[k].exp));
            if (k == 0) chk("upd at first valid", u, UPD ? 32'd18 : 32'd0);
            if (k == 7) chk("dut0 last accept load", 32'(o0[5]), 32'd1);
            if (k == 8) chk("dut0 done next", 32'({o0[5], o0[1]}), 32'b01);
        end

        // Randomized sessions, with occasional mid-session resets.
        for (int sess = 0; sess < 12; sess++) begin
            do_reset();
            for (int c = 0; c < 80; c++) begin
                if ($urandom_range(0, 59) == 0) begin
                    do_reset();
                end else begin
                    step(($urandom_range(0, 7) == 0), $urandom_range(0, 1) == 1,
                         ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0), o, o0, u);
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
